// File: rtl/instruction_encoder_loader_if.sv
// ---------------------------------------------------------------------------
// instruction_encoder_loader_if
// Bundle of the field-level producer handshake and the instruction-memory
// write port used by instruction_encoder_loader.
//   master : the producer / memory side (drives session control, fields,
//            memStall; observes inReady, write port and status)
//   slave  : the encoder/loader itself
// Signals:
//   start, baseAddr                       session control
//   inValid, inReady, inLast              bundle handshake
//   fmt, opcode, rsAdd, rtAdd, shift,
//   immediate, label, offset              instruction fields
//   memWe, memAddr, memData, memStall     memory write port
//   done, overflow, wordCount             session status
// ---------------------------------------------------------------------------
interface instruction_encoder_loader_if #(
   parameter int ADDR_W = 10
);
   logic              start;
   logic [ADDR_W-1:0] baseAddr;
   logic              inValid;
   logic              inReady;
   logic              inLast;
   logic [1:0]        fmt;
   logic [5:0]        opcode;
   logic [4:0]        rsAdd;
   logic [4:0]        rtAdd;
   logic [4:0]        shift;
   logic [20:0]       immediate;
   logic [25:0]       label;
   logic [15:0]       offset;
   logic              memWe;
   logic [ADDR_W-1:0] memAddr;
   logic [31:0]       memData;
   logic              memStall;
   logic              done;
   logic              overflow;
   logic [ADDR_W:0]   wordCount;

   modport master (
      output start, baseAddr, inValid, inLast, fmt, opcode, rsAdd, rtAdd,
             shift, immediate, label, offset, memStall,
      input  inReady, memWe, memAddr, memData, done, overflow, wordCount
   );

   modport slave (
      input  start, baseAddr, inValid, inLast, fmt, opcode, rsAdd, rtAdd,
             shift, immediate, label, offset, memStall,
      output inReady, memWe, memAddr, memData, done, overflow, wordCount
   );
endinterface

// File: rtl/instruction_encoder_loader.sv
// ---------------------------------------------------------------------------
// instruction_encoder_loader
// Packs KGP-RISC instruction fields into 32-bit words and writes them to
// consecutive instruction-memory word addresses starting at baseAddr.
// A 2-entry FIFO between the field handshake and the memory write port
// absorbs arbiter stalls while keeping 1 word/cycle throughput.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-low
//   bus  : instruction_encoder_loader_if.slave (handshake, fields,
//          memory write port, done/overflow/wordCount status)
// ---------------------------------------------------------------------------
module instruction_encoder_loader #(
   parameter int ADDR_W = 10
) (
   input logic                         clk,
   input logic                         rst,
   instruction_encoder_loader_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DRAIN,
      S_DONE,
      S_ERROR
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W:0]   wcount;
   logic              done_r;
   logic              ovf_r;

   // FIFO entry: {last flag, encoded word}
   logic [32:0]       fifo [2];
   logic              rd_idx;
   logic              wr_idx;
   logic [1:0]        count;

   logic [31:0]       enc_word_p0;
   logic              in_ready;
   logic              mem_we;
   logic              push;
   logic              pop;
   logic              head_last;
   logic              at_end;

   function automatic logic [31:0] encode(
      input logic [1:0]  fmt,
      input logic [5:0]  opcode,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [4:0]  sh,
      input logic [20:0] imm,
      input logic [25:0] lbl,
      input logic [15:0] off
   );
      logic [31:0] w;
      case (fmt)
         2'd0:    w = {opcode, rs, rt, sh, 11'b0};
         2'd1:    w = {opcode, rs, imm};
         2'd2:    w = {opcode, lbl};
         default: w = {opcode, rs, rt, off};
      endcase
      return w;
   endfunction

   always_comb begin
      enc_word_p0 = encode(bus.fmt, bus.opcode, bus.rsAdd, bus.rtAdd,
                           bus.shift, bus.immediate, bus.label, bus.offset);
   end

   // inReady depends only on registered state, never on memStall
   assign in_ready  = (state == S_LOAD) && (count != 2'd2);
   assign mem_we    = ((state == S_LOAD) || (state == S_DRAIN)) && (count != 2'd0);
   assign push      = bus.inValid && in_ready;
   assign pop       = mem_we && !bus.memStall;
   assign head_last = fifo[rd_idx][32];
   assign at_end    = &ptr;

   assign bus.inReady   = in_ready;
   assign bus.memWe     = mem_we;
   assign bus.memAddr   = ptr;
   // gated so the data bus reads zero whenever no write is requested
   assign bus.memData   = mem_we ? fifo[rd_idx][31:0] : 32'd0;
   assign bus.done      = done_r;
   assign bus.overflow  = ovf_r;
   assign bus.wordCount = wcount;

   // --- stage p0 -> FIFO storage: encoded word and last flag ---
   always_ff @(posedge clk) begin
      if (push) begin
         fifo[wr_idx] <= {bus.inLast, enc_word_p0};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= S_IDLE;
         ptr    <= '0;
         wcount <= '0;
         done_r <= 1'b0;
         ovf_r  <= 1'b0;
         count  <= 2'd0;
         rd_idx <= 1'b0;
         wr_idx <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (bus.start) begin
                  state  <= S_LOAD;
                  ptr    <= bus.baseAddr;
                  wcount <= '0;
                  done_r <= 1'b0;
                  ovf_r  <= 1'b0;
                  count  <= 2'd0;
                  rd_idx <= 1'b0;
                  wr_idx <= 1'b0;
               end
            end
            S_LOAD, S_DRAIN: begin
               if (push) begin
                  wr_idx <= ~wr_idx;
               end
               if (pop) begin
                  rd_idx <= ~rd_idx;
               end
               count <= count + 2'(push) - 2'(pop);
               if (push && bus.inLast) begin
                  state <= S_DRAIN;
               end
               if (pop) begin
                  wcount <= wcount + (ADDR_W+1)'(1);
                  // ptr parks at the top address instead of wrapping
                  if (!at_end) begin
                     ptr <= ptr + ADDR_W'(1);
                  end
                  if (head_last) begin
                     state  <= S_DONE;
                     done_r <= 1'b1;
                  end else if (at_end) begin
                     // address space exhausted: discard whatever is queued
                     state <= S_ERROR;
                     ovf_r <= 1'b1;
                     count <= 2'd0;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_encoder_loader.sv
module tb_instruction_encoder_loader;

   typedef struct {
      logic [1:0]  fmt;
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  sh;
      logic [20:0] imm;
      logic [25:0] lbl;
      logic [15:0] off;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        start;
   logic [9:0]  base;
   logic        in_valid;
   logic        in_last;
   logic [1:0]  fmt;
   logic [5:0]  opcode;
   logic [4:0]  rs_add;
   logic [4:0]  rt_add;
   logic [4:0]  shamt;
   logic [20:0] imm;
   logic [25:0] lbl;
   logic [15:0] off;
   logic        mem_stall;

   logic        in_ready;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_data;
   logic        done;
   logic        ovf;
   logic [10:0] wc;

   int          checks = 0;
   int          errors = 0;
   vec_t        vt [6];
   wr_t         sb [$];

   always #5 clk = ~clk;

   instruction_encoder_loader_if #(.ADDR_W(10)) bus_a ();
   instruction_encoder_loader_if #(.ADDR_W(2))  bus_b ();

   instruction_encoder_loader #(.ADDR_W(10)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   instruction_encoder_loader #(.ADDR_W(2))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   assign bus_a.start     = start & ~sel;
   assign bus_b.start     = start & sel;
   assign bus_a.baseAddr  = base;
   assign bus_b.baseAddr  = base[1:0];
   assign bus_a.inValid   = in_valid & ~sel;
   assign bus_b.inValid   = in_valid & sel;
   assign bus_a.inLast    = in_last;
   assign bus_b.inLast    = in_last;
   assign bus_a.fmt       = fmt;
   assign bus_b.fmt       = fmt;
   assign bus_a.opcode    = opcode;
   assign bus_b.opcode    = opcode;
   assign bus_a.rsAdd     = rs_add;
   assign bus_b.rsAdd     = rs_add;
   assign bus_a.rtAdd     = rt_add;
   assign bus_b.rtAdd     = rt_add;
   assign bus_a.shift     = shamt;
   assign bus_b.shift     = shamt;
   assign bus_a.immediate = imm;
   assign bus_b.immediate = imm;
   assign bus_a.label     = lbl;
   assign bus_b.label     = lbl;
   assign bus_a.offset    = off;
   assign bus_b.offset    = off;
   assign bus_a.memStall  = mem_stall;
   assign bus_b.memStall  = mem_stall;

   assign in_ready = sel ? bus_b.inReady  : bus_a.inReady;
   assign mem_we   = sel ? bus_b.memWe    : bus_a.memWe;
   assign mem_addr = sel ? {8'd0, bus_b.memAddr} : bus_a.memAddr;
   assign mem_data = sel ? bus_b.memData  : bus_a.memData;
   assign done     = sel ? bus_b.done     : bus_a.done;
   assign ovf      = sel ? bus_b.overflow : bus_a.overflow;
   assign wc       = sel ? {8'd0, bus_b.wordCount} : bus_a.wordCount;

   // write log: a request seen at the falling edge commits at the next rising edge
   always @(negedge clk) begin
      if (rst && mem_we && !mem_stall) begin
         sb.push_back('{addr: mem_addr, data: mem_data});
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_session(input logic [9:0] b);
      base  = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      @(negedge clk);
      chk("inready_after_start", in_ready, 1);
      tick();
   endtask

   task automatic send(input vec_t v, input logic last, input int budget, output bit acc);
      fmt     = v.fmt;
      opcode  = v.op;
      rs_add  = v.rs;
      rt_add  = v.rt;
      shamt   = v.sh;
      imm     = v.imm;
      lbl     = v.lbl;
      off     = v.off;
      in_last = last;
      in_valid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < budget && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_ok(input vec_t v, input logic last);
      bit acc;
      send(v, last, 20, acc);
      chk("handshake", acc, 1);
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      chk("done", done, 1);
      tick();
   endtask

   initial begin
      vt[0] = '{fmt: 2'd0, op: 6'h00, rs: 5'd8,  rt: 5'd9,  sh: 5'd0,  imm: 21'h0ABCD,  lbl: 26'h155,     off: 16'h1234, exp: 32'h01090000};
      vt[1] = '{fmt: 2'd1, op: 6'h01, rs: 5'd3,  rt: 5'h1F, sh: 5'h1F, imm: 21'h1FFFFF, lbl: 26'h0,       off: 16'h0,    exp: 32'h047FFFFF};
      vt[2] = '{fmt: 2'd2, op: 6'h20, rs: 5'h1F, rt: 5'h1F, sh: 5'h1F, imm: 21'h1FFFFF, lbl: 26'h10,      off: 16'hFFFF, exp: 32'h80000010};
      vt[3] = '{fmt: 2'd3, op: 6'h10, rs: 5'd1,  rt: 5'd2,  sh: 5'd7,  imm: 21'h0,      lbl: 26'h3FFFFFF, off: 16'hFFFC, exp: 32'h4022FFFC};
      vt[4] = '{fmt: 2'd0, op: 6'h00, rs: 5'd1,  rt: 5'd2,  sh: 5'd5,  imm: 21'h1FFFFF, lbl: 26'h3FFFFFF, off: 16'hFFFF, exp: 32'h00222800};
      vt[5] = '{fmt: 2'd3, op: 6'h3F, rs: 5'h1F, rt: 5'h1F, sh: 5'h1F, imm: 21'h1FFFFF, lbl: 26'h0,       off: 16'h0000, exp: 32'hFFFF0000};

      rst = 1'b0; sel = 1'b0; start = 1'b0; base = '0; in_valid = 1'b0; in_last = 1'b0;
      fmt = '0; opcode = '0; rs_add = '0; rt_add = '0; shamt = '0; imm = '0; lbl = '0; off = '0;
      mem_stall = 1'b0;
      repeat (2) tick();

      // reset state
      @(negedge clk);
      chk("rst_inready", in_ready, 0);
      chk("rst_memwe", mem_we, 0);
      chk("rst_memaddr", mem_addr, 0);
      chk("rst_memdata", mem_data, 0);
      chk("rst_done", done, 0);
      chk("rst_overflow", ovf, 0);
      chk("rst_wordcount", wc, 0);
      tick();
      rst = 1'b1;
      tick();

      // single R-type word, write visible the cycle after acceptance
      sb.delete();
      begin_session(10'd0);
      send_ok(vt[0], 1'b1);
      @(negedge clk);
      chk("r_memwe", mem_we, 1);
      chk("r_memaddr", mem_addr, 0);
      chk("r_memdata", mem_data, 32'h01090000);
      tick();
      wait_done();
      @(negedge clk);
      chk("r_wordcount", wc, 1);
      chk("r_writes", sb.size(), 1);
      tick();

      // format table at base 5
      sb.delete();
      begin_session(10'd5);
      for (int i = 1; i < 6; i++) send_ok(vt[i], i == 5);
      wait_done();
      chk("fmt_writes", sb.size(), 5);
      for (int i = 1; i < 6; i++) begin
         if (sb.size() >= i) begin
            chk("fmt_addr", sb[i-1].addr, 10'd4 + 10'(i));
            chk("fmt_data", sb[i-1].data, vt[i].exp);
         end
      end
      @(negedge clk);
      chk("fmt_wordcount", wc, 5);
      tick();

      // streaming with a 3-cycle stall after the first commit
      sb.delete();
      begin_session(10'd16);
      fork
         begin
            for (int i = 0; i < 6; i++) send_ok(vt[i], i == 5);
         end
         begin
            logic [9:0]  a0;
            logic [31:0] d0;
            for (int k = 0; k < 50 && sb.size() == 0; k++) @(negedge clk);
            tick();
            mem_stall = 1'b1;
            @(negedge clk);
            a0 = mem_addr;
            d0 = mem_data;
            for (int j = 0; j < 3; j++) begin
               if (j > 0) @(negedge clk);
               chk("stall_memwe", mem_we, 1);
               chk("stall_addr", mem_addr, a0);
               chk("stall_data", mem_data, d0);
               if (j == 2) chk("stall_inready", in_ready, 0);
            end
            tick();
            mem_stall = 1'b0;
         end
      join
      wait_done();
      chk("stream_writes", sb.size(), 6);
      for (int i = 0; i < 6; i++) begin
         if (sb.size() > i) begin
            chk("stream_addr", sb[i].addr, 10'd16 + 10'(i));
            chk("stream_data", sb[i].data, vt[i].exp);
         end
      end
      @(negedge clk);
      chk("stream_wordcount", wc, 6);
      tick();

      // overflow on the 2-bit address instance
      sel = 1'b1;
      sb.delete();
      begin_session(10'd2);
      for (int i = 0; i < 4; i++) begin
         bit acc;
         send(vt[i], 1'b0, 6, acc);
      end
      repeat (3) tick();
      @(negedge clk);
      chk("ovf_writes", sb.size(), 2);
      if (sb.size() >= 2) begin
         chk("ovf_addr0", sb[0].addr, 2);
         chk("ovf_addr1", sb[1].addr, 3);
         chk("ovf_data0", sb[0].data, vt[0].exp);
         chk("ovf_data1", sb[1].data, vt[1].exp);
      end
      chk("ovf_overflow", ovf, 1);
      chk("ovf_done", done, 0);
      chk("ovf_wordcount", wc, 2);
      chk("ovf_inready", in_ready, 0);
      chk("ovf_memwe", mem_we, 0);
      tick();

      // last word exactly at the top address
      sb.delete();
      begin_session(10'd3);
      send_ok(vt[2], 1'b1);
      wait_done();
      @(negedge clk);
      chk("edge_writes", sb.size(), 1);
      if (sb.size() >= 1) chk("edge_addr", sb[0].addr, 3);
      chk("edge_overflow", ovf, 0);
      chk("edge_wordcount", wc, 1);
      tick();
      sel = 1'b0;

      // start ignored mid-session, then reset mid-session
      sb.delete();
      begin_session(10'h040);
      send_ok(vt[0], 1'b0);
      base  = 10'h100;
      start = 1'b1;
      send_ok(vt[1], 1'b0);
      start = 1'b0;
      mem_stall = 1'b1;
      @(negedge clk);
      chk("ctl_ptr", mem_addr, 10'h041);
      chk("ctl_memwe", mem_we, 1);
      chk("ctl_memdata", mem_data, vt[1].exp);
      chk("ctl_wordcount", wc, 1);
      tick();
      rst = 1'b0;
      tick();
      @(negedge clk);
      chk("mrst_inready", in_ready, 0);
      chk("mrst_memwe", mem_we, 0);
      chk("mrst_memaddr", mem_addr, 0);
      chk("mrst_memdata", mem_data, 0);
      chk("mrst_done", done, 0);
      chk("mrst_overflow", ovf, 0);
      chk("mrst_wordcount", wc, 0);
      tick();
      rst = 1'b1;
      mem_stall = 1'b0;
      begin
         bit any_we;
         any_we = 1'b0;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            any_we = any_we | mem_we;
         end
         chk("mrst_no_write", any_we, 0);
      end
      chk("mrst_log", sb.size(), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
